// File: rtl/rx_top_pkg.sv
// Shared definitions for the UART receiver: FSM state codes, sample-point
// helpers derived from the oversampling ratio, and default widths.
package rx_top_pkg;

    localparam int unsigned DEF_PRESCALE   = 8;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    // Three sample points centred on the middle of a bit period.
    function automatic int unsigned samp_first(input int unsigned prescale);
        return prescale / 2 - 1;
    endfunction

    function automatic int unsigned samp_mid(input int unsigned prescale);
        return prescale / 2;
    endfunction

    function automatic int unsigned samp_last(input int unsigned prescale);
        return prescale / 2 + 1;
    endfunction

endpackage

// File: rtl/rx_top_data_sampler.sv
// Three-point majority sampler: captures the line at the first two sample
// points and votes with the live line value at the third.
module data_sampler
    import rx_top_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] edge_cnt,
    input  logic             rx,
    output logic             maj,
    output logic             samp_done
);

    localparam logic [CNT_W-1:0] SAMP_1 = CNT_W'(samp_first(PRESCALE));
    localparam logic [CNT_W-1:0] SAMP_2 = CNT_W'(samp_mid(PRESCALE));
    localparam logic [CNT_W-1:0] SAMP_3 = CNT_W'(samp_last(PRESCALE));

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Capture the first two samples of the current bit.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (en && (edge_cnt == SAMP_1)) s1_d = rx;
        if (en && (edge_cnt == SAMP_2)) s2_d = rx;
    end

    // Sample registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign maj       = (s1_q & s2_q) | (s1_q & rx) | (s2_q & rx);
    assign samp_done = en && (edge_cnt == SAMP_3);

endmodule

// File: rtl/rx_top.sv
// UART receiver: synchronizer, frame FSM, edge/bit counters, LSB-first
// deserializer and parity/stop checking with one-cycle result pulses.
module rx_top
    import rx_top_pkg::*;
#(
    parameter int unsigned PRESCALE   = DEF_PRESCALE,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    localparam int unsigned CNT_W  = $clog2(PRESCALE);
    localparam int unsigned BCNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [BCNT_W-1:0] BITS_FULL = BCNT_W'(DATA_WIDTH);

    logic                  rx_meta_q, rx_meta_d;
    logic                  rx_sync_q, rx_sync_d;
    logic                  rx_prev_q, rx_prev_d;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_flag_q, par_flag_d;
    logic                  start_bad_q, start_bad_d;
    logic                  fall_pend_q, fall_pend_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_err_q, stop_err_d;

    logic fall;
    logic cnt_last;
    logic maj;
    logic samp_done;

    assign fall     = rx_prev_q & ~rx_sync_q;
    assign cnt_last = (edge_cnt_q == CNT_LAST);
    assign busy     = (state_q != ST_IDLE);

    data_sampler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .en        (busy),
        .edge_cnt  (edge_cnt_q),
        .rx        (rx_sync_q),
        .maj       (maj),
        .samp_done (samp_done)
    );

    // Next-state logic: frame sequencing, counting, shifting and checks.
    always_comb begin
        rx_meta_d    = RX_IN;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_flag_d   = par_flag_q;
        start_bad_d  = start_bad_q;
        fall_pend_d  = fall_pend_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stop_err_d   = 1'b0;

        if (state_q != ST_IDLE) begin
            edge_cnt_d = cnt_last ? '0 : edge_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d  = '0;
                fall_pend_d = 1'b0;
                if (fall || fall_pend_q) begin
                    // Frame options are frozen here for the whole frame.
                    state_d     = ST_START;
                    par_en_d    = PAR_EN;
                    par_typ_d   = PAR_TYP;
                    par_flag_d  = 1'b0;
                    start_bad_d = 1'b0;
                    bit_cnt_d   = '0;
                end
            end
            ST_START: begin
                if (samp_done) start_bad_d = maj;
                if (cnt_last) state_d = start_bad_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (samp_done) begin
                    shift_d   = {maj, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (cnt_last && (bit_cnt_q == BITS_FULL)) begin
                    bit_cnt_d = '0;
                    state_d   = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (samp_done && (maj != ((^shift_q) ^ par_typ_q))) par_flag_d = 1'b1;
                if (cnt_last) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Results are registered so the pulses coincide with DONE.
                if (samp_done) begin
                    state_d      = ST_DONE;
                    data_valid_d = maj & ~par_flag_q;
                    par_err_d    = par_flag_q;
                    stop_err_d   = ~maj;
                    if (maj && !par_flag_q) p_data_d = shift_q;
                end
            end
            ST_DONE: begin
                // A start edge arriving now would be lost by IDLE's edge detector.
                state_d     = ST_IDLE;
                fall_pend_d = fall;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= ST_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_flag_q   <= 1'b0;
            start_bad_q  <= 1'b0;
            fall_pend_q  <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_flag_q   <= par_flag_d;
            start_bad_q  <= start_bad_d;
            fall_pend_q  <= fall_pend_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stop_err   = stop_err_q;

endmodule

// File: tb/tb_rx_top.sv
// Self-checking bench for rx_top: directed frames plus randomized traffic,
// compared against a frame-level model of expected result pulses.
module tb_rx_top;

    localparam int P  = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          data_valid, par_err, stop_err, busy;

    rx_top #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit            dv;
        bit            pe;
        bit            se;
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [DW-1:0] last_good = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Every result pulse must match the next predicted frame outcome.
    always @(negedge clk) begin
        if (!rst && (data_valid || par_err || stop_err)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {29'd0, data_valid, par_err, stop_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pulse_kind", {29'd0, data_valid, par_err, stop_err},
                         {29'd0, e.dv, e.pe, e.se});
                check_eq("pulse_cycle", cyc, e.cyc);
                check_eq("p_data", {24'd0, P_DATA}, {24'd0, e.data});
            end
        end
    end

    // Drive one frame and predict its outcome. The result appears after two
    // synchronizer cycles plus the frame latency from the synchronized edge.
    task automatic send_frame(input logic [DW-1:0] data, input bit pe, input bit pt,
                              input bit bad_par, input bit stop_bit);
        exp_t x;
        bit   perr;
        bit   serr;
        PAR_EN  = pe;
        PAR_TYP = pt;
        perr  = pe && bad_par;
        serr  = !stop_bit;
        x.dv  = !perr && !serr;
        x.pe  = perr;
        x.se  = serr;
        x.cyc = cyc + 2 + (1 + DW + int'(pe)) * P + P / 2 + 3;
        if (x.dv) last_good = data;
        x.data = last_good;
        exp_q.push_back(x);

        RX_IN = 1'b0;
        repeat (P) @(negedge clk);
        // Option inputs are now latched; wiggling them must not matter.
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        for (int i = 0; i < DW; i++) begin
            RX_IN = data[i];
            repeat (P) @(negedge clk);
        end
        if (pe) begin
            RX_IN = (^data) ^ pt ^ bad_par;
            repeat (P) @(negedge clk);
        end
        RX_IN = stop_bit;
        repeat (P) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_p_data"}, {24'd0, P_DATA}, 32'd0);
        check_eq({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
        check_eq({tag, "_par_err"}, {31'd0, par_err}, 32'd0);
        check_eq({tag, "_stop_err"}, {31'd0, stop_err}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        bit            sb;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle(4);

        // Plain frame, no parity.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        // Even parity with a wrong parity bit: P_DATA must keep 0xA5.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);
        // Stop bit low.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Two-cycle glitch: START entered then rejected without pulses.
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (2 * P) @(negedge clk);
        check_eq("glitch_busy_low", {31'd0, busy}, 32'd0);

        // Back-to-back frames with odd parity.
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(4);

        // Reset in the middle of data bit 4.
        d = 8'h6B;
        PAR_EN = 1'b0;
        RX_IN  = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX_IN = d[i];
            repeat (P) @(negedge clk);
        end
        RX_IN = d[4];
        repeat (P / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midframe_rst");
        rst   = 1'b0;
        RX_IN = 1'b1;
        last_good = '0;
        idle(2 * P);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Randomized traffic, including back-to-back frames.
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(d, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), sb);
            if (!sb) idle($urandom_range(2, 5));
            else     idle($urandom_range(0, 3));
        end

        idle(4 * P);
        check_eq("missing_pulses", exp_q.size(), 32'd0);
        check_eq("final_busy", {31'd0, busy}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
